// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/clear and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            // Drop everything: read side catches up with the write side.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory reads for PC control and hands
// {pc, inst} pairs to decode, discarding wrong-path responses after a redirect.
module fetch_unit #(
    parameter int unsigned ADDR_W = fetch_pkg::ADDR_W,
    parameter int unsigned INST_W = fetch_pkg::INST_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_fetch,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              pcsel,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // The PC queue holds exactly the in-flight requests, so its occupancy is
    // the outstanding count.
    logic [CNT_W-1:0]        outstanding;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        drop;
    logic [CNT_W:0]          in_use;
    logic                    credit;
    logic                    accept;
    logic                    keep;
    logic                    dec_pop;
    logic [ADDR_W-1:0]       pcq_head;
    logic [ADDR_W+INST_W-1:0] outq_head;

    always_comb begin
        in_use        = {1'b0, outstanding} + {1'b0, count};
        credit        = in_use < (CNT_W + 1)'(DEPTH);
        mem_req_valid = !reset && pc_valid && credit && !pcsel;
        pc_ready      = mem_req_valid && mem_req_ready;
        accept        = pc_ready;
        keep          = !reset && mem_resp_valid && (drop == '0) && !pcsel;
        dec_valid     = !reset && (count != '0) && !pcsel;
        dec_pop       = dec_valid && dec_ready;
        mem_req_addr  = {pc_fetch[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop <= '0;
        end else if (pcsel) begin
            // Everything still in flight is wrong-path, except a response
            // landing this very cycle, which is discarded directly.
            drop <= outstanding - CNT_W'(mem_resp_valid);
        end else if (mem_resp_valid && (drop != '0)) begin
            drop <= drop - CNT_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (pc_fetch),
        .pop   (mem_resp_valid),
        .clear (1'b0),
        .rdata (pcq_head),
        .count (outstanding)
    );

    fetch_fifo #(
        .WIDTH (ADDR_W + INST_W),
        .DEPTH (DEPTH)
    ) u_out_queue (
        .clk   (clk),
        .reset (reset),
        .push  (keep),
        .wdata ({pcq_head, mem_resp_data}),
        .pop   (dec_pop),
        .clear (pcsel),
        .rdata (outq_head),
        .count (count)
    );

    assign dec_pc   = outq_head[ADDR_W+INST_W-1:INST_W];
    assign dec_inst = outq_head[INST_W-1:0];

endmodule
